midi_out_arbiter: RTL and testbench

- Shares one MIDI output sender bus (cmd/ch/data1/data2 with valid/rd/busy) between NUM_SRC command sources, e.g. the register-bus command FIFO and a hardware sequencer.
- Pops one message at a time from the round-robin winner into a one-entry output register.
- Contains a panic sequencer that, on request, pre-empts all sources and emits Control Change PANIC_CC, value 0, on MIDI channels 0..15 in order.

---
 rtl/midi_out_arbiter.sv | 158 +++++++++++++++
 tb/tb_midi_out_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_out_arbiter.sv
// midi_out_arbiter: round-robin arbiter sharing one MIDI sender among NUM_SRC sources, with a panic sequencer
//   clk, rst (sync, active-low)
//   src_valid/src_rd              per-source FWFT handshake (src_rd is a one-cycle pop strobe)
//   src_cmd/src_ch/src_data1/2    packed per-source message fields
//   out_valid/out_rd/out_busy     one-entry output register handshake; out_busy blocks new grants
//   out_cmd/out_ch/out_data1/2    registered message fields
//   out_src/out_is_panic          origin of the held message
//   panic_req/panic_busy          start / progress of the all-channels Control Change sequence
`timescale 1ns/1ps
module midi_out_arbiter #(
    parameter int         NUM_SRC  = 2,
    parameter logic [6:0] PANIC_CC = 7'd123,
    parameter int         IDXW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SRC-1:0]     src_valid,
    output logic [NUM_SRC-1:0]     src_rd,
    input  logic [4*NUM_SRC-1:0]   src_cmd,
    input  logic [4*NUM_SRC-1:0]   src_ch,
    input  logic [7*NUM_SRC-1:0]   src_data1,
    input  logic [7*NUM_SRC-1:0]   src_data2,
    output logic                   out_valid,
    input  logic                   out_rd,
    input  logic                   out_busy,
    output logic [3:0]             out_cmd,
    output logic [3:0]             out_ch,
    output logic [6:0]             out_data1,
    output logic [6:0]             out_data2,
    output logic [IDXW-1:0]        out_src,
    output logic                   out_is_panic,
    input  logic                   panic_req,
    output logic                   panic_busy
);
    localparam logic [IDXW-1:0] LAST = IDXW'(NUM_SRC - 1);

    typedef enum logic {IDLE, FULL} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   rr_q, rr_d, src_q, src_d;
    logic [3:0]        cmd_q, cmd_d, ch_q, ch_d, pch_q, pch_d;
    logic [6:0]        d1_q, d1_d, d2_q, d2_d;
    logic              ispan_q, ispan_d, pend_q, pend_d, pbusy_q, pbusy_d;
    logic [NUM_SRC-1:0] rd_d;
    logic [IDXW-1:0]   win, idx;
    logic              found;

    logic [3:0] cmd_a [NUM_SRC];
    logic [3:0] ch_a  [NUM_SRC];
    logic [6:0] d1_a  [NUM_SRC];
    logic [6:0] d2_a  [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign cmd_a[g] = src_cmd[4*g+3:4*g];
        assign ch_a[g]  = src_ch[4*g+3:4*g];
        assign d1_a[g]  = src_data1[7*g+6:7*g];
        assign d2_a[g]  = src_data2[7*g+6:7*g];
    end

    // First valid source scanning upward from the RR pointer, wrapping at NUM_SRC.
    always_comb begin
        win   = rr_q;
        found = 1'b0;
        idx   = rr_q;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && src_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
            idx = (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        src_d   = src_q;
        cmd_d   = cmd_q;
        ch_d    = ch_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        ispan_d = ispan_q;
        pch_d   = pch_q;
        pend_d  = pend_q;
        pbusy_d = pbusy_q;
        rd_d    = '0;
        // A request while a sequence is pending or running is dropped; there is no restart.
        if (panic_req && !pbusy_q) begin
            pend_d  = 1'b1;
            pbusy_d = 1'b1;
        end
        if (state_q == IDLE) begin
            if (!out_busy && pend_q) begin
                cmd_d   = 4'hB;
                ch_d    = pch_q;
                d1_d    = PANIC_CC;
                d2_d    = '0;
                src_d   = '0;
                ispan_d = 1'b1;
                pch_d   = pch_q + 4'd1;
                pend_d  = (pch_q != 4'hF);
                state_d = FULL;
            end else if (!out_busy && !pbusy_q && found) begin
                rd_d[win] = 1'b1;
                cmd_d     = cmd_a[win];
                ch_d      = ch_a[win];
                d1_d      = d1_a[win];
                d2_d      = d2_a[win];
                src_d     = win;
                ispan_d   = 1'b0;
                rr_d      = (win == LAST) ? '0 : win + 1'b1;
                state_d   = FULL;
            end
        end else if (out_rd) begin
            state_d = IDLE;
            // The sequence is finished once its channel-15 message leaves the register.
            if (ispan_q && ch_q == 4'hF) pbusy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            src_q   <= '0;
            cmd_q   <= '0;
            ch_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            ispan_q <= 1'b0;
            pch_q   <= '0;
            pend_q  <= 1'b0;
            pbusy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            src_q   <= src_d;
            cmd_q   <= cmd_d;
            ch_q    <= ch_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            ispan_q <= ispan_d;
            pch_q   <= pch_d;
            pend_q  <= pend_d;
            pbusy_q <= pbusy_d;
        end
    end

    assign src_rd       = rst ? rd_d : '0;
    assign out_valid    = (state_q == FULL);
    assign out_cmd      = cmd_q;
    assign out_ch       = ch_q;
    assign out_data1    = d1_q;
    assign out_data2    = d2_q;
    assign out_src      = src_q;
    assign out_is_panic = ispan_q;
    assign panic_busy   = pbusy_q;
endmodule

// File: tb/tb_midi_out_arbiter.sv
// tb_midi_out_arbiter: randomized scoreboard bench for midi_out_arbiter
`timescale 1ns/1ps
module tb_midi_out_arbiter;
    localparam int N  = 2;
    localparam int IW = 1;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]   src_valid, src_rd;
    logic [4*N-1:0] src_cmd, src_ch;
    logic [7*N-1:0] src_data1, src_data2;
    logic           out_valid, out_rd, out_busy, out_is_panic, panic_req, panic_busy;
    logic [3:0]     out_cmd, out_ch;
    logic [6:0]     out_data1, out_data2;
    logic [IW-1:0]  out_src;

    always #5 clk = ~clk;

    midi_out_arbiter #(.NUM_SRC(N), .PANIC_CC(7'd123)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_rd(src_rd),
        .src_cmd(src_cmd), .src_ch(src_ch), .src_data1(src_data1), .src_data2(src_data2),
        .out_valid(out_valid), .out_rd(out_rd), .out_busy(out_busy),
        .out_cmd(out_cmd), .out_ch(out_ch), .out_data1(out_data1), .out_data2(out_data2),
        .out_src(out_src), .out_is_panic(out_is_panic),
        .panic_req(panic_req), .panic_busy(panic_busy)
    );

    typedef struct {
        logic [3:0] cmd;
        logic [3:0] ch;
        logic [6:0] d1;
        logic [6:0] d2;
        int         src;
        logic       pan;
    } msg_t;

    msg_t srcq [N][$];
    msg_t exp_q [$];
    int   pan_ch [$];
    int   errors = 0;
    int   checks = 0;
    int   pan_seen = 0;
    int   grants [N];
    bit   m_hold, m_pbusy, m_last, m_held_pan;
    int   m_rr, m_held_ch;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every cycle the register is full, it must match the oldest expected message.
    always @(negedge clk) begin : mon
        msg_t e;
        if (rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got out_valid=1 expected no message at %0t", $time);
            end else begin
                e = exp_q[0];
                chk("out_cmd", int'(out_cmd), int'(e.cmd));
                chk("out_ch", int'(out_ch), int'(e.ch));
                chk("out_data1", int'(out_data1), int'(e.d1));
                chk("out_data2", int'(out_data2), int'(e.d2));
                chk("out_src", int'(out_src), e.src);
                chk("out_is_panic", int'(out_is_panic), int'(e.pan));
                if (out_rd) begin
                    if (out_is_panic) pan_seen++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // One clock of stimulus plus the reference model's view of what that clock does.
    task automatic step(bit do_rst, int p_rd, int p_busy, int p_pan, int p_new, int p_gate);
        logic [N-1:0] exp_rd;
        bit   hold_n, pb_n;
        int   idx;
        msg_t m;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(99) < p_new && srcq[i].size() < 4) begin
                m.cmd = 4'($urandom);
                m.ch  = 4'($urandom);
                m.d1  = 7'($urandom);
                m.d2  = 7'($urandom);
                m.src = i;
                m.pan = 1'b0;
                srcq[i].push_back(m);
            end
        end
        rst = !do_rst;
        for (int i = 0; i < N; i++) begin
            src_valid[i] = (srcq[i].size() > 0) && ($urandom_range(99) < p_gate);
            if (srcq[i].size() > 0) begin
                src_cmd[4*i +: 4]   = srcq[i][0].cmd;
                src_ch[4*i +: 4]    = srcq[i][0].ch;
                src_data1[7*i +: 7] = srcq[i][0].d1;
                src_data2[7*i +: 7] = srcq[i][0].d2;
            end else begin
                src_cmd[4*i +: 4]   = 4'($urandom);
                src_ch[4*i +: 4]    = 4'($urandom);
                src_data1[7*i +: 7] = 7'($urandom);
                src_data2[7*i +: 7] = 7'($urandom);
            end
        end
        out_rd    = $urandom_range(99) < p_rd;
        out_busy  = $urandom_range(99) < p_busy;
        panic_req = !do_rst && ($urandom_range(99) < p_pan);
        #1;
        chk("out_valid", int'(out_valid), int'(m_hold));
        chk("panic_busy", int'(panic_busy), int'(m_pbusy));
        exp_rd = '0;
        hold_n = m_hold;
        pb_n   = m_pbusy;
        if (m_hold && out_rd) begin
            hold_n = 1'b0;
            if (m_held_pan && m_last) pb_n = 1'b0;
        end
        if (!do_rst && !m_hold && !out_busy) begin
            if (m_pbusy) begin
                m_held_ch = pan_ch.pop_front();
                m = '{4'hB, 4'(m_held_ch), 7'd123, 7'd0, 0, 1'b1};
                exp_q.push_back(m);
                m_last     = (pan_ch.size() == 0);
                m_held_pan = 1'b1;
                hold_n     = 1'b1;
            end else if (src_valid != '0) begin
                idx = m_rr;
                while (!src_valid[IW'(idx)]) idx = (idx + 1) % N;
                exp_rd[IW'(idx)] = 1'b1;
                exp_q.push_back(srcq[idx].pop_front());
                m_rr       = (idx + 1) % N;
                m_held_pan = 1'b0;
                hold_n     = 1'b1;
                grants[idx]++;
            end
        end
        if (panic_req && !m_pbusy) begin
            pb_n = 1'b1;
            for (int c = 0; c < 16; c++) pan_ch.push_back(c);
        end
        chk("src_rd", int'(src_rd), int'(exp_rd));
        if (do_rst) begin
            hold_n     = 1'b0;
            pb_n       = 1'b0;
            m_rr       = 0;
            m_held_pan = 1'b0;
            pan_ch.delete();
            exp_q.delete();
        end
        m_hold  = hold_n;
        m_pbusy = pb_n;
    endtask

    task automatic zero_chk();
        @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_cmd", int'(out_cmd), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_out_data1", int'(out_data1), 0);
        chk("rst_out_data2", int'(out_data2), 0);
        chk("rst_out_src", int'(out_src), 0);
        chk("rst_out_is_panic", int'(out_is_panic), 0);
        chk("rst_panic_busy", int'(panic_busy), 0);
        chk("rst_src_rd", int'(src_rd), 0);
    endtask

    task automatic push_msg(int s, int cmd, int ch, int d1, int d2);
        msg_t m;
        m = '{4'(cmd), 4'(ch), 7'(d1), 7'(d2), s, 1'b0};
        srcq[s].push_back(m);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, start;
        rst = 1'b0;
        src_valid = '0; src_cmd = '0; src_ch = '0; src_data1 = '0; src_data2 = '0;
        out_rd = 1'b0; out_busy = 1'b0; panic_req = 1'b0;
        m_hold = 0; m_pbusy = 0; m_last = 0; m_held_pan = 0; m_rr = 0; m_held_ch = 0;
        for (int i = 0; i < N; i++) grants[i] = 0;

        step(1, 0, 0, 0, 0, 100);
        step(1, 0, 0, 0, 0, 100);
        zero_chk();

        // single source, then hold for 20 cycles, then consume
        push_msg(0, 9, 3, 60, 100);
        step(0, 0, 0, 0, 0, 100);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 100);
        for (int i = 0; i < 3; i++) step(0, 100, 0, 0, 0, 100);

        // backpressure, then release
        push_msg(0, 8, 1, 10, 20);
        push_msg(1, 9, 2, 30, 40);
        for (int i = 0; i < 10; i++) step(0, 100, 100, 0, 0, 100);
        for (int i = 0; i < 6; i++) step(0, 100, 0, 0, 0, 100);

        // fairness with both sources always valid
        for (int i = 0; i < N; i++) grants[i] = 0;
        for (int i = 0; i < 4; i++) push_msg(i % N, i, i, i, i);
        for (int i = 0; i < 16; i++) step(0, 100, 0, 0, 100, 100);
        chk("fair_g0", grants[0], 4);
        chk("fair_g1", grants[1], 4);

        // panic while a source message is held, with repeated requests mid-sequence
        n = 0;
        while (!m_hold && n < 50) begin step(0, 0, 0, 0, 100, 100); n++; end
        chk("held_before_panic", int'(m_hold), 1);
        start = pan_seen;
        step(0, 0, 0, 100, 50, 100);
        n = 0;
        while (m_pbusy && n < 400) begin
            step(0, 60, 20, (n < 10 || (n > 20 && n < 25)) ? 100 : 0, 50, 90);
            n++;
        end
        step(0, 60, 20, 0, 50, 90);
        chk("panic_done", int'(m_pbusy), 0);
        chk("panic_count", pan_seen - start, 16);

        // randomized traffic with occasional panics
        for (int i = 0; i < 3000; i++) step(0, 60, 20, 1, 30, 85);

        // reset while the channel-7 panic message is held
        n = 0;
        while (m_pbusy && n < 400) begin step(0, 80, 0, 0, 0, 100); n++; end
        step(0, 80, 0, 100, 30, 90);
        n = 0;
        while (!(m_hold && m_held_pan && m_held_ch == 7) && n < 200) begin
            step(0, 50, 10, 0, 30, 90);
            n++;
        end
        chk("reached_ch7", int'(m_hold && m_held_pan && m_held_ch == 7), 1);
        step(1, 0, 0, 0, 0, 100);
        zero_chk();
        for (int i = 0; i < N; i++) if (srcq[i].size() == 0) push_msg(i, 12, i, 5, 6);
        for (int i = 0; i < 200; i++) step(0, 60, 10, 0, 30, 90);

        // drain
        for (int i = 0; i < 100; i++) step(0, 100, 0, 0, 0, 100);
        chk("drain_exp", exp_q.size(), 0);
        chk("drain_src0", srcq[0].size(), 0);
        chk("drain_src1", srcq[1].size(), 0);
        chk("drain_pbusy", int'(panic_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
